// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter owning a 2**ADDR_W x DATA_W memory array
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic own, last_gnt, we_q, pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign pick = (req0 & req1) ? ~last_gnt : req1;
  // array is never cleared; a reset on the access edge suppresses the write
  always_ff @(posedge clock)
    if (!reset && state == ACCESS && we_q) mem[addr_q] <= wdata_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      last_gnt <= 1'b1;
      own      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          own      <= pick;
          last_gnt <= pick;
          we_q     <= pick ? we1 : we0;
          addr_q   <= pick ? addr1 : addr0;
          wdata_q  <= pick ? wdata1 : wdata0;
          gnt      <= pick ? 2'b10 : 2'b01;
          busy     <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (!we_q && own) rdata1 <= mem[addr_q];
          if (!we_q && !own) rdata0 <= mem[addr_q];
          ack0  <= ~own;
          ack1  <= own;
          state <= RESP;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the accumulator CPU's 32x8 main memory. It owns the memory array and shares it between port 0 (CPU fetch/execute) and port 1 (program loader / debug monitor). It uses a per-port level request / one-cycle acknowledge handshake with round-robin priority. With it, the loader can fill or inspect memory while the CPU runs, without corrupting any in-flight access.

## Interface
- ADDR_W, 5, address width; array depth is 2**ADDR_W (32 words).
- DATA_W, 8, word width.
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- req0  in  1  port 0 (CPU) access request, level.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 access complete, one-cycle pulse.
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1, held until port 0's next read ack.
- req1, we1, addr1, wdata1, ack1, rdata1: port 1 (loader), same widths and meaning.
- gnt  out  2  one-hot current owner (01 = port 0, 10 = port 1, 00 = none).
- busy  out  1  1 when the state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: evaluate req0/req1.
  - No request: stay in IDLE, gnt=00.
  - One request: grant that port.
  - Both requests: grant the port that did not win the previous grant (last_gnt). This is round-robin.
  - On grant: latch the owner's we/addr/wdata into internal registers, set gnt, update last_gnt, go to ACCESS.
- ACCESS: perform the latched operation on the array.
  - Write: mem[addr] <= wdata.
  - Read: the owner's rdata register <= mem[addr]; the other port's rdata is unchanged.
  - Set the owner's ack=1 and go to RESP.
- RESP: clear ack, gnt=00, go to IDLE.
- Requester rules:
  - Hold we/addr/wdata stable from raising req until the grant edge. Inputs are latched at grant, so later changes do not affect the in-flight access.
  - A req still high in the IDLE cycle after ack counts as a new request.
- The non-owner's req is ignored while busy=1. It is never dropped: it is evaluated at the next IDLE.
- Reset:
  - State=IDLE; gnt=00; busy=0; ack0=ack1=0; rdata0=rdata1=0.
  - last_gnt=port 1, so port 0 (CPU) wins the first tie.
  - Array contents are NOT cleared by reset.
- Reset mid-operation:
  - Reset asserted in ACCESS has priority: no write is committed, no rdata update, no ack.
  - Reset asserted in RESP clears ack immediately at that edge.
- Read of an address in the same ACCESS edge as nothing else: no write/read collision is possible, because only one port owns the array at a time.
- Read-after-write to the same address by the other port returns the new data (write completes before the next grant).

## Timing
- Edge E0, IDLE with req sampled: grant latched; gnt/busy high during E0–E1.
- Edge E1: array access; ack high during E1–E2; rdata valid in the same cycle.
- Edge E2: back to IDLE; ack, gnt and busy return to 0.
- Edge E3 is the earliest next grant.
- Fixed latency: 2 edges from sampled request to ack.
- Peak throughput: one access per 3 cycles.
- Fairness: under continuous requests on both ports, grants alternate 0,1,0,1…. Maximum wait is one foreign access (3 cycles) plus the current one.
- All outputs are registered; no combinational path from req to ack/gnt.

## Test plan
- Reset, then req0 read addr 5 with mem[5]=8'h00 -> ack0 exactly 2 edges after the request edge, rdata0=8'h00, ack1 never asserts, gnt=01 then 00.
- Port 1 writes 8'b11101000 @0 and 8'h0F @3, then port 0 reads 0 and 3 -> rdata0=8'hE8 then 8'h0F; port 1's rdata1 is unchanged.
- req0 and req1 both held high from reset, four accesses -> grant order 0,1,0,1; each ack is a single cycle; busy drops for exactly one IDLE cycle between accesses.
- req1 arrives while port 0 is in ACCESS -> port 1 is granted at the next IDLE edge, not earlier, and port 0's access completes unaffected.
- Port 0 write 8'h55 @7 with reset asserted on the ACCESS edge -> mem[7] keeps its old value, no ack0, state IDLE, gnt=00; a later read of 7 returns the old value.
- Port 0 changes addr0 from 3 to 4 one cycle after the grant -> the access uses addr 3 (latched value).
